mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (I) and data load/store (D).
//  - Sequences each access and formats byte/half/word data per MemType/MemSign encoding.
//  - Raises Stall_o while either requester is waiting.
//  - Sits between fetch/memory stages and the memory model; D has fixed priority (older instr).

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port has fixed priority over fetch; formats byte/half/word.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned data accesses with DErr_o instead of issuing them.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  IReq_i,
  input  logic [ADDR_WIDTH-1:0] IAddr_i,
  output logic                  IAck_o,
  output logic [DATA_WIDTH-1:0] IData_o,
  input  logic                  DReq_i,
  input  logic                  DWe_i,
  input  logic [ADDR_WIDTH-1:0] DAddr_i,
  input  logic [DATA_WIDTH-1:0] DWData_i,
  input  logic [1:0]            DMemType_i,
  input  logic                  DMemSign_i,
  output logic                  DAck_o,
  output logic [DATA_WIDTH-1:0] DRData_o,
  output logic                  DErr_o,
  output logic                  Stall_o,
  output logic                  MemEn_o,
  output logic                  MemWe_o,
  output logic [ADDR_WIDTH-1:0] MemAddr_o,
  output logic [DATA_WIDTH-1:0] MemWData_o,
  output logic [3:0]            MemBe_o,
  input  logic [DATA_WIDTH-1:0] MemRData_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q;
  logic            own_d_q, we_q, sign_q, err_q, err_pulse;
  logic [1:0]      type_q, lane_q;
  logic            start, trap;
  logic [1:0]      lane;
  logic [3:0]      be;
  logic [DATA_WIDTH-1:0] wrep, load_fmt, sh8, sh16;
  logic [ADDR_WIDTH-1:0] addr;
  logic            unused_lsb;

  assign start      = DReq_i | IReq_i;
  assign lane       = DAddr_i[1:0];
  assign addr       = DReq_i ? DAddr_i : IAddr_i;
  assign unused_lsb = ^IAddr_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = DReq_i & ((DMemType_i == 2'b10 & lane[0]) |
                          ((DMemType_i == 2'b00 | DMemType_i == 2'b11) & (|lane)));
`else
  assign trap = 1'b0;
`endif

  // Store lane placement; misaligned halves/words fall back to the aligned lane.
  always_comb begin
    be   = 4'hF;
    wrep = DWData_i;
    case (DMemType_i)
      2'b01: begin be = 4'b0001 << lane;            wrep = {4{DWData_i[7:0]}};  end
      2'b10: begin be = 4'b0011 << {lane[1], 1'b0}; wrep = {2{DWData_i[15:0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    sh8  = MemRData_i >> {lane_q, 3'b000};
    sh16 = MemRData_i >> {lane_q[1], 4'b0000};
    case (type_q)
      2'b01:   load_fmt = {{24{sign_q & sh8[7]}}, sh8[7:0]};
      2'b10:   load_fmt = {{16{sign_q & sh16[15]}}, sh16[15:0]};
      default: load_fmt = MemRData_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_d_q    <= 1'b0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      type_q     <= '0;
      lane_q     <= '0;
      MemEn_o    <= 1'b0;
      MemWe_o    <= 1'b0;
      MemAddr_o  <= '0;
      MemWData_o <= '0;
      MemBe_o    <= '0;
    end else begin
      state_q    <= state_d;
      MemEn_o    <= 1'b0;
      MemWe_o    <= 1'b0;
      MemAddr_o  <= '0;
      MemWData_o <= '0;
      MemBe_o    <= '0;
      // Memory strobes are registered at acceptance so they line up with the ISSUE cycle.
      if (state_q == IDLE && start) begin
        own_d_q <= DReq_i;
        we_q    <= DReq_i & DWe_i;
        type_q  <= DReq_i ? DMemType_i : 2'b00;
        sign_q  <= DReq_i & DMemSign_i;
        lane_q  <= DReq_i ? lane : 2'b00;
        err_q   <= trap;
        if (!trap) begin
          MemEn_o    <= 1'b1;
          MemWe_o    <= DReq_i & DWe_i;
          MemAddr_o  <= {addr[ADDR_WIDTH-1:2], 2'b00};
          MemBe_o    <= DReq_i ? be : 4'hF;
          MemWData_o <= (DReq_i & DWe_i) ? wrep : '0;
        end
      end
      if (state_q == ISSUE)
        cnt_q <= 3'(READ_LATENCY - 1);
      else if (state_q == WAIT && cnt_q != 3'd0)
        cnt_q <= cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    IAck_o    = 1'b0;
    DAck_o    = 1'b0;
    err_pulse = 1'b0;
    IData_o   = '0;
    DRData_o  = '0;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        if (err_q) begin
          DAck_o    = 1'b1;
          err_pulse = 1'b1;
          state_d   = IDLE;
        end else if (we_q) begin
          DAck_o  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          if (own_d_q) begin
            DAck_o   = 1'b1;
            DRData_o = load_fmt;
          end else begin
            IAck_o  = 1'b1;
            IData_o = MemRData_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // err_q is never set without the trap macro, so DErr_o stays 0 in that build.
  assign DErr_o  = err_pulse;
  assign Stall_o = (IReq_i & ~IAck_o) | (DReq_i & ~DAck_o);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random traffic against a byte-array memory reference.
module tb_mem_port_arbiter;
  localparam int RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni, IReq_i, IAck_o, DReq_i, DWe_i, DMemSign_i, DAck_o, DErr_o, Stall_o;
  logic        MemEn_o, MemWe_o;
  logic [31:0] IAddr_i, IData_o, DAddr_i, DWData_i, DRData_o, MemAddr_o, MemWData_o, MemRData_i;
  logic [1:0]  DMemType_i;
  logic [3:0]  MemBe_o;

  int tests = 0, fails = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(RL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IAck_o(IAck_o), .IData_o(IData_o),
    .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i), .DWData_i(DWData_i),
    .DMemType_i(DMemType_i), .DMemSign_i(DMemSign_i), .DAck_o(DAck_o), .DRData_o(DRData_o),
    .DErr_o(DErr_o), .Stall_o(Stall_o), .MemEn_o(MemEn_o), .MemWe_o(MemWe_o),
    .MemAddr_o(MemAddr_o), .MemWData_o(MemWData_o), .MemBe_o(MemBe_o), .MemRData_i(MemRData_i)
  );

  // Memory model: 1 KiB, byte-enabled writes, reads returned RL cycles after the strobe.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:RL-1];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;
  assign MemRData_i = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (MemEn_o && MemWe_o)
      for (int b = 0; b < 4; b++)
        if (MemBe_o[b]) mem[MemAddr_o[9:2]][8*b +: 8] <= MemWData_o[8*b +: 8];
    rd_pipe[0] <= (MemEn_o && !MemWe_o) ? mem[MemAddr_o[9:2]] : $urandom;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference: plain byte array, accesses described as (aligned base, byte count).
  logic [7:0] refb [0:1023];

  function automatic int nbytes(input logic [1:0] mt);
    return (mt == 2'b01) ? 1 : (mt == 2'b10) ? 2 : 4;
  endfunction

  function automatic int base_of(input logic [31:0] a, input logic [1:0] mt);
    return int'(a[9:0]) & ~(nbytes(mt) - 1);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] mt, input bit sg);
    logic [31:0] v = 0;
    int n = nbytes(mt), b = base_of(a, mt);
    for (int k = 0; k < n; k++) v[8*k +: 8] = refb[b + k];
    if (sg && n < 4 && v[8*n - 1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit is_trap(input logic [31:0] a, input logic [1:0] mt);
`ifdef MEM_MISALIGN_TRAP_EN
    return (a % nbytes(mt)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    pre_we = 1'b1; pre_idx = a[9:2]; pre_dat = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
    for (int k = 0; k < 4; k++) refb[{a[9:2], 2'b00} + k] = v[8*k +: 8];
  endtask

  // One isolated transaction; entered and left at #1 after an edge with the DUT idle.
  task automatic xact(input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] mt, input bit sg, input bit scramble);
    bit trap, wr, ack;
    int lat, cyc, n, b;
    logic [31:0] exp_d, ewd;
    logic [3:0]  ebe;
    trap  = is_d && is_trap(a, mt);
    wr    = is_d && we;
    lat   = (trap || wr) ? 1 : 1 + RL;
    exp_d = trap || wr ? 32'h0 : is_d ? ref_load(a, mt, sg) : ref_load(a, 2'b00, 1'b0);
    n = is_d ? nbytes(mt) : 4;
    b = is_d ? base_of(a, mt) : base_of(a, 2'b00);
    ebe = 4'h0;
    for (int k = 0; k < n; k++) ebe[(b + k) % 4] = 1'b1;
    for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wd[8*(k % n) +: 8];
    if (is_d) begin
      DReq_i = 1'b1; DWe_i = we; DAddr_i = a; DWData_i = wd; DMemType_i = mt; DMemSign_i = sg;
    end else begin
      IReq_i = 1'b1; IAddr_i = a;
    end
    #1 chk("stall_t0", Stall_o, 1);
    cyc = 0; ack = 1'b0;
    while (!ack && cyc < 12) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        chk("mem_en", MemEn_o, !trap);
        if (!trap) begin
          chk("mem_addr", MemAddr_o, {22'h0, a[9:2], 2'b00});
          chk("mem_we", MemWe_o, wr);
          if (wr || !is_d) chk("mem_be", MemBe_o, ebe);
          if (wr) chk("mem_wdata", MemWData_o, ewd);
        end
      end
      ack = is_d ? DAck_o : IAck_o;
      if (!ack) chk("stall_wait", Stall_o, 1);
      if (!ack && scramble && is_d) begin
        DAddr_i = $urandom; DMemType_i = 2'($urandom); DMemSign_i = 1'($urandom);
        DWe_i = 1'($urandom); DWData_i = $urandom;
      end
    end
    chk("ack_latency", cyc, lat);
    if (ack) begin
      chk("rdata", is_d ? DRData_o : IData_o, exp_d);
      chk("other_ack", is_d ? IAck_o : DAck_o, 0);
      chk("err", DErr_o, trap);
      chk("stall_ack", Stall_o, 0);
    end
    DReq_i = 1'b0; IReq_i = 1'b0;
    if (wr && !trap) for (int k = 0; k < n; k++) refb[b + k] = wd[8*(k % n) +: 8];
    @(posedge clk); #1;
    chk("idle_no_issue", MemEn_o, 0);
  endtask

  initial begin
    int cyc, dc, ic;
    logic [31:0] exp_dd, exp_i;
    rst_ni = 1'b0; IReq_i = 0; IAddr_i = 0; DReq_i = 0; DWe_i = 0; DAddr_i = 0;
    DWData_i = 0; DMemType_i = 0; DMemSign_i = 0;
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
    chk("rst_memen", MemEn_o, 0);
    chk("rst_acks", {IAck_o, DAck_o, DErr_o, Stall_o}, 0);
    chk("rst_bus", MemAddr_o | MemWData_o | {28'h0, MemBe_o} | IData_o | DRData_o, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    set_word(32'h100, 32'h00500513);
    xact(0, 0, 32'h100, 0, 2'b00, 0, 0);

    set_word(32'h300, 32'h12C4_0000);
    exp_dd = ref_load(32'h302, 2'b01, 1'b1);
    exp_i  = ref_load(32'h100, 2'b00, 1'b0);
    DReq_i = 1; DWe_i = 0; DAddr_i = 32'h302; DMemType_i = 2'b01; DMemSign_i = 1;
    IReq_i = 1; IAddr_i = 32'h100;
    cyc = 0; dc = 0; ic = 0;
    while (ic == 0 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (DAck_o) begin dc = cyc; chk("both_drdata", DRData_o, exp_dd); DReq_i = 0; end
      if (IAck_o) begin ic = cyc; chk("both_idata", IData_o, exp_i); end
      else chk("both_stall", Stall_o, 1);
      if (dc != 0 && cyc == dc + 2) chk("both_i_issue", {MemEn_o, MemAddr_o[30:0]}, {1'b1, 31'h100});
    end
    chk("both_dack_cyc", dc, 1 + RL);
    chk("both_iack_cyc", ic, 3 + 2 * RL);
    IReq_i = 0;
    @(posedge clk); #1;

    xact(1, 1, 32'h203, 32'h0000_00AB, 2'b01, 0, 0);
    xact(1, 1, 32'h202, 32'h0000_1234, 2'b10, 0, 0);
    xact(1, 0, 32'h200, 0, 2'b00, 0, 0);

    set_word(32'h200, 32'h0000_F000);
    xact(1, 0, 32'h201, 0, 2'b01, 1, 0);
    xact(1, 0, 32'h201, 0, 2'b01, 0, 0);
    set_word(32'h200, 32'h8000_0000);
    xact(1, 0, 32'h202, 0, 2'b10, 1, 0);
    xact(1, 0, 32'h202, 0, 2'b10, 0, 0);

    xact(1, 0, 32'h102, 0, 2'b00, 0, 0);
    xact(1, 1, 32'h101, 32'hBEEF_CAFE, 2'b10, 0, 0);

    for (int i = 0; i < 60; i++)
      xact($urandom_range(0, 2) != 0, 1'($urandom), 32'($urandom_range(0, 1023)), $urandom,
           2'($urandom), 1'($urandom), 1'b1);

    IReq_i = 1; IAddr_i = 32'h104;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 0; IReq_i = 0;
    #1;
    chk("rst_mid_iack", {IAck_o, DAck_o, Stall_o, MemEn_o}, 0);
    chk("rst_mid_idata", IData_o, 0);
    @(posedge clk); #1;
    chk("rst_hold_iack", IAck_o, 0);
    rst_ni = 1;
    @(posedge clk); #1;
    xact(0, 0, 32'h104, 0, 2'b00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
